// File: rtl/result_display_mux_if.sv
// Bundle between the result bus producer and the 7-segment display driver.
// The master drives value/load and the slave (the display driver) drives the board pins.
interface result_display_mux_if;
   logic [15:0] value;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   modport master (output value, load, input  seg, dp, an, frame_tick);
   modport slave  (input  value, load, output seg, dp, an, frame_tick);
endinterface

// File: rtl/result_display_mux.sv
// Scans a 16-bit value onto a 4-digit hex 7-segment display, latching it only at frame wrap.
// an/seg are registered one clk behind the digit index; there is no backpressure.
module result_display_mux #(
   parameter int REFRESH_DIV    = 50000,
   parameter bit BLANK_LZ       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   result_display_mux_if.slave disp
);
   localparam int             CW      = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0]     AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   frame_buf;
   logic          load_pending;
   logic          frame_tick_q;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;

   logic          wrap;
   logic          boundary;
   logic [3:0]    nib;
   logic          zero_3;
   logic          zero_32;
   logic          zero_321;
   logic          blank;
   logic [6:0]    hex;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_nxt;

   assign wrap     = (cnt == CNT_MAX);
   assign boundary = wrap && (idx == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (wrap) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // A load seen on the boundary cycle itself captures directly and never sets pending.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_buf    <= 16'h0000;
         load_pending <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= boundary;
         if (boundary) begin
            if (load_pending || disp.load) begin
               frame_buf <= disp.value;
            end
            load_pending <= 1'b0;
         end else if (disp.load) begin
            load_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      nib      = frame_buf[{idx, 2'b00} +: 4];
      zero_3   = (frame_buf[15:12] == 4'h0);
      zero_32  = zero_3  && (frame_buf[11:8] == 4'h0);
      zero_321 = zero_32 && (frame_buf[7:4]  == 4'h0);
      blank    = 1'b0;
      case (idx)
         2'd1:    blank = zero_321;
         2'd2:    blank = zero_32;
         2'd3:    blank = zero_3;
         default: blank = 1'b0;
      endcase
      blank = blank && BLANK_LZ;

      hex = 7'h00;
      case (nib)
         4'h0: hex = 7'h3F;
         4'h1: hex = 7'h06;
         4'h2: hex = 7'h5B;
         4'h3: hex = 7'h4F;
         4'h4: hex = 7'h66;
         4'h5: hex = 7'h6D;
         4'h6: hex = 7'h7D;
         4'h7: hex = 7'h07;
         4'h8: hex = 7'h7F;
         4'h9: hex = 7'h6F;
         4'hA: hex = 7'h77;
         4'hB: hex = 7'h7C;
         4'hC: hex = 7'h39;
         4'hD: hex = 7'h5E;
         4'hE: hex = 7'h79;
         default: hex = 7'h71;
      endcase

      seg_nxt = blank ? 7'h00 : hex;
      if (SEG_ACTIVE_LOW) begin
         seg_nxt = ~seg_nxt;
      end
      an_nxt = 4'b0001 << idx;
      if (AN_ACTIVE_LOW) begin
         an_nxt = ~an_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
      end else begin
         an_q  <= an_nxt;
         seg_q <= seg_nxt;
      end
   end

   assign disp.an         = an_q;
   assign disp.seg        = seg_q;
   assign disp.dp         = SEG_ACTIVE_LOW;
   assign disp.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_result_display_mux.sv
module tb_result_display_mux;
   localparam int R = 4;
   localparam int F = 4 * R;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] value = 16'h0000;
   logic        load  = 1'b0;

   always #5 clk = ~clk;

   result_display_mux_if if_lz ();
   result_display_mux_if if_nz ();

   assign if_lz.value = value;
   assign if_lz.load  = load;
   assign if_nz.value = value;
   assign if_nz.load  = load;

   result_display_mux #(.REFRESH_DIV(R), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
      u_lz (.clk(clk), .reset(reset), .disp(if_lz));
   result_display_mux #(.REFRESH_DIV(R), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
      u_nz (.clk(clk), .reset(reset), .disp(if_nz));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: k counts clock edges since reset release, everything else follows arithmetically.
   logic [6:0]  hex_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int          k;
   logic [15:0] mbuf;
   bit          mpend;
   logic [3:0]  e_an;
   logic [6:0]  e_lz;
   logic [6:0]  e_nz;
   logic        e_tick;

   function automatic logic [6:0] exp_seg(input logic [15:0] b, input int d, input bit blank_lz);
      int bi;
      int nib;
      bi  = int'(b);
      nib = (bi >> (4 * d)) & 15;
      if (blank_lz && d > 0 && (bi >> (4 * d)) == 0) return 7'h7F;
      return ~hex_tab[nib];
   endfunction

   task automatic model_reset();
      k      = 0;
      mbuf   = 16'h0000;
      mpend  = 1'b0;
      e_an   = 4'hF;
      e_lz   = 7'h7F;
      e_nz   = 7'h7F;
      e_tick = 1'b0;
   endtask

   task automatic model_edge();
      int d;
      bit bnd;
      d   = (k / R) % 4;
      bnd = (k % F) == F - 1;
      e_an    = 4'hF;
      e_an[d] = 1'b0;
      e_lz    = exp_seg(mbuf, d, 1'b1);
      e_nz    = exp_seg(mbuf, d, 1'b0);
      e_tick  = bnd;
      if (bnd) begin
         if (mpend || load) mbuf = value;
         mpend = 1'b0;
      end else if (load) begin
         mpend = 1'b1;
      end
      k++;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("an_lz",   16'(if_lz.an),         16'(e_an));
      chk("an_nz",   16'(if_nz.an),         16'(e_an));
      chk("seg_lz",  16'(if_lz.seg),        16'(e_lz));
      chk("seg_nz",  16'(if_nz.seg),        16'(e_nz));
      chk("dp_lz",   16'(if_lz.dp),         16'h0001);
      chk("dp_nz",   16'(if_nz.dp),         16'h0001);
      chk("tick_lz", 16'(if_lz.frame_tick), 16'(e_tick));
      chk("tick_nz", 16'(if_nz.frame_tick), 16'(e_tick));
   endtask

   task automatic step();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Waits (bounded) for a frame_tick, then checks one whole frame digit by digit against constants.
   task automatic check_frame(input string tag, input logic [27:0] x_lz, input logic [27:0] x_nz);
      bit found;
      int d;
      found = 1'b0;
      for (int i = 0; i < F + 2 && !found; i++) begin
         if (if_lz.frame_tick === 1'b1) found = 1'b1;
         else step();
      end
      chk({tag, "_tick_seen"}, 16'(found), 16'h0001);
      for (int j = 0; j < F; j++) begin
         step();
         d = j / R;
         chk({tag, "_seg_lz"}, 16'(if_lz.seg), 16'(x_lz[7*d +: 7]));
         chk({tag, "_seg_nz"}, 16'(if_nz.seg), 16'(x_nz[7*d +: 7]));
      end
   endtask

   initial begin
      model_reset();

      // 1: reset held, then free-running scan of 0000
      repeat (3) begin
         @(negedge clk);
         check_all();
      end
      reset = 1'b1;
      repeat (2 * F) step();

      // 2: single-cycle load mid-frame
      for (int i = 0; i < F && (k % F) != 6; i++) step();
      value = 16'h1234;
      load  = 1'b1;
      step();
      load  = 1'b0;
      check_frame("t2", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19});
      repeat (10) begin
         value = 16'($urandom);
         step();
      end

      // 3: leading-zero blanking with load held high
      value = 16'h00A0;
      load  = 1'b1;
      step();
      check_frame("t3", {7'h7F, 7'h7F, 7'h08, 7'h40}, {7'h40, 7'h40, 7'h08, 7'h40});

      // 4: load held while value changes every cycle
      repeat (3 * F) begin
         value = 16'($urandom);
         step();
      end
      load = 1'b0;
      repeat (F) begin
         value = 16'($urandom);
         step();
      end

      // 5: asynchronous reset while digit 2 is lit
      value = 16'hABCD;
      load  = 1'b1;
      step();
      load  = 1'b0;
      for (int i = 0; i < 2 * F && !((k / R) % 4 == 2 && (k % R) == 1); i++) step();
      #2 reset = 1'b0;
      #1;
      chk("t5_async_an_lz",  16'(if_lz.an),         16'h000F);
      chk("t5_async_an_nz",  16'(if_nz.an),         16'h000F);
      chk("t5_async_seg_lz", 16'(if_lz.seg),        16'h007F);
      chk("t5_async_seg_nz", 16'(if_nz.seg),        16'h007F);
      chk("t5_async_tick",   16'(if_lz.frame_tick), 16'h0000);
      model_reset();
      repeat (2) step();
      reset = 1'b1;
      repeat (F + R) step();

      // 6: load exactly on the boundary cycle, then no stale pending
      for (int i = 0; i < F && (k % F) != F - 1; i++) step();
      value = 16'hFFFF;
      load  = 1'b1;
      step();
      load  = 1'b0;
      value = 16'h0000;
      check_frame("t6", {7'h0E, 7'h0E, 7'h0E, 7'h0E}, {7'h0E, 7'h0E, 7'h0E, 7'h0E});
      repeat (F + R) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/result_display_mux.md
Name: result_display_mux

Overview:
- Downstream consumer of the processor's 16-bit `result` bus.
- Drives a 4-digit common-anode 7-segment display on the board with the value as four hex digits.
- Time-multiplexes the digits and captures the value only at frame boundaries, so no digit tears mid-frame.
- Optionally blanks leading zeros.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays lit (min 2).
- BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is never blanked.
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (0 lights the segment).
- AN_ACTIVE_LOW, 1, 1 = anode outputs inverted (0 enables the digit).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- value  input  16  data to display (processor `result`).
- load  input  1  capture request; level-sensitive, may be held high for continuous update.
- seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a.
- dp  output  1  decimal point; held off (1 if SEG_ACTIVE_LOW, else 0).
- an  output  4  digit enables; an[0] = least-significant nibble.
- frame_tick  output  1  one-cycle pulse when digit index wraps 3->0.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-low. Asserting it mid-operation immediately forces the reset state, regardless of clk.
- Reset state:
  - refresh counter = 0, digit index = 0.
  - frame_buf = 16'h0000, load_pending = 0, frame_tick = 0.
  - an = all digits disabled; seg = all segments off; dp = off.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index advances 0->1->2->3->0 (2-bit, natural wrap).
- Frame boundary: the cycle in which the counter wraps while digit index = 3. At that edge:
  - digit index becomes 0.
  - frame_tick = 1 for exactly that following cycle.
  - If load_pending = 1 or load = 1, then frame_buf <= value (sampled that cycle) and load_pending <= 0.
- load_pending:
  - Set on any cycle with load = 1 that is not a frame boundary.
  - Cleared only by a capture.
  - load asserted on the boundary cycle itself captures directly and leaves pending clear.
- Capture timing: value changes between captures are invisible. Worst-case latency from load to display is 4*REFRESH_DIV + 1 cycles.
- Digit nibble: nib = frame_buf[4*idx+3 : 4*idx].
- Leading-zero blanking (BLANK_LZ = 1): digit i (i = 1..3) is blanked when nib_i = 0 and every higher nibble = 0.
  - Blanked digit: its anode is still enabled, segments are all off.
  - Example: 16'h0000 shows only "0" on digit 0; 16'h0400 shows "400".
- Hex encoding, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - SEG_ACTIVE_LOW inverts these values.
- Outputs registered:
  - an and seg reflect the new digit index one clk after the index changes.
  - Exactly one anode is enabled at all times after the first post-reset cycle, with no overlap.
  - an and seg switch on the same edge.
- Anode decode: one-hot on digit index (idx 0 -> an = 4'b1110 when AN_ACTIVE_LOW).
- First post-reset cycle: an switches from all-off to digit 0 enabled; seg shows nib_0 of 0 → "0".
- Reset release timing: deassertion is synchronous to clk by the usual integrator; no internal synchronizer is required.

Test Plan (REFRESH_DIV = 4, all active-low defaults):
1. Reset held low 3 cycles, then released, value = 16'h0000, load = 0.
   - During reset: an = 4'b1111, seg = 7'h7F.
   - After release: an cycles 1110/1101/1011/0111, with each pattern held 4 cycles.
   - seg = 7'h40 ("0") on digit 0, 7'h7F on digits 1-3.
   - frame_tick pulses every 16 cycles.
2. value = 16'h1234, load pulsed 1 cycle mid-frame.
   - Display is unchanged until the next frame_tick, then frame_buf = 1234.
   - seg per digit 0..3: 0x19, 0x30, 0x24, 0x79.
3. BLANK_LZ = 1, value = 16'h00A0, load held high.
   - Digits 3 and 2 show seg = 7'h7F; digit 1 shows 'A' = 7'h08; digit 0 shows '0' = 7'h40.
   - Repeat with BLANK_LZ = 0: digits 3 and 2 show 7'h40.
4. load held high while value changes every cycle.
   - frame_buf equals the value sampled on each frame-boundary cycle only.
   - No seg change occurs within a frame except at digit switches.
5. Reset asserted mid-frame while digit index = 2.
   - Same cycle (asynchronous): an = 4'b1111, seg off, frame_buf = 0.
   - After release: scanning restarts at digit 0 with counter = 0.
6. load pulsed exactly on the frame-boundary cycle with value = 16'hFFFF.
   - Captured immediately; load_pending stays 0.
   - All four digits show 'F' = 7'h0E.
